// File: rtl/adc_spi_reader.sv
// SPI ADC reader: asserts conv_L, waits out the conversion, shifts WID bits MSB-first, then holds the word under an arm/finished handshake.
// Optional macro ADC_SPI_READER_MISO_SYNC_EN puts a two-flop synchronizer on miso with unchanged latency.
module adc_spi_reader #(
  parameter int WID             = 18,
  parameter int WID_LEN         = 5,
  parameter int POLARITY        = 1,
  parameter int PHASE           = 0,
  parameter int CYCLE_HALF_WAIT = 1,
  parameter int CONV_WAIT       = 4,
  parameter int TIMER_LEN       = 16
) (
  input  logic           clk,
  input  logic           rst_L,
  input  logic           arm,
  output logic           finished,
  output logic [WID-1:0] data,
  input  logic           miso,
  output logic           sck,
  output logic           conv_L
);

  localparam logic SCK_IDLE = (POLARITY != 0);
  localparam logic SAMPLE_TRAILING = (PHASE != 0);

  typedef enum logic [1:0] {IDLE, CONV, SHIFT, DONE} state_t;

  state_t               state_q;
  logic [TIMER_LEN-1:0] timer_q;
  logic [WID_LEN-1:0]   bit_cnt_q;
  logic [WID-1:0]       shreg_q;
  logic [WID-1:0]       shreg_d;
  logic                 sck_q;
  logic                 conv_L_q;
  logic                 finished_q;
  logic [WID-1:0]       data_q;
  logic                 miso_s;
  logic                 sample_now;

  if (2 ** WID_LEN <= WID) begin : g_wid_len_chk
    $error("WID_LEN too narrow for WID");
  end

`ifdef ADC_SPI_READER_MISO_SYNC_EN
  logic [1:0] miso_sync_q;

  if (CYCLE_HALF_WAIT < 2) begin : g_sync_chk
    $error("CYCLE_HALF_WAIT must be >= 2 with the miso synchronizer");
  end

  always_ff @(posedge clk) begin
    if (!rst_L) miso_sync_q <= '0;
    else        miso_sync_q <= {miso_sync_q[0], miso};
  end

  always_comb miso_s = miso_sync_q[1];
`else
  always_comb miso_s = miso;
`endif

  // The edge about to be generated leaves the idle level when sck_q is idle (leading edge).
  always_comb begin
    sample_now = (sck_q == SCK_IDLE) ^ SAMPLE_TRAILING;
    shreg_d    = {shreg_q[WID-2:0], miso_s};
  end

  always_ff @(posedge clk) begin
    if (!rst_L) begin
      state_q    <= IDLE;
      timer_q    <= '0;
      bit_cnt_q  <= '0;
      shreg_q    <= '0;
      sck_q      <= SCK_IDLE;
      conv_L_q   <= 1'b1;
      finished_q <= 1'b0;
      data_q     <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          sck_q      <= SCK_IDLE;
          conv_L_q   <= 1'b1;
          finished_q <= 1'b0;
          timer_q    <= '0;
          bit_cnt_q  <= '0;
          if (arm) state_q <= CONV;
        end
        CONV: begin
          // conv_L drops on the first CONV cycle; the wait timer runs from the next one.
          if (conv_L_q) begin
            conv_L_q <= 1'b0;
          end else if (timer_q == TIMER_LEN'(CONV_WAIT)) begin
            timer_q <= '0;
            state_q <= SHIFT;
            sck_q   <= ~sck_q;
            if (sample_now) begin
              shreg_q   <= shreg_d;
              bit_cnt_q <= bit_cnt_q + WID_LEN'(1);
            end
          end else begin
            timer_q <= timer_q + TIMER_LEN'(1);
          end
        end
        SHIFT: begin
          if (timer_q == TIMER_LEN'(CYCLE_HALF_WAIT)) begin
            timer_q <= '0;
            if (bit_cnt_q == WID_LEN'(WID) && sck_q == SCK_IDLE) begin
              state_q    <= DONE;
              conv_L_q   <= 1'b1;
              finished_q <= 1'b1;
              data_q     <= shreg_q;
            end else begin
              sck_q <= ~sck_q;
              if (sample_now) begin
                shreg_q   <= shreg_d;
                bit_cnt_q <= bit_cnt_q + WID_LEN'(1);
              end
            end
          end else begin
            timer_q <= timer_q + TIMER_LEN'(1);
          end
        end
        DONE: begin
          if (!arm) begin
            finished_q <= 1'b0;
            state_q    <= IDLE;
          end
        end
      endcase
    end
  end

  assign finished = finished_q;
  assign data     = data_q;
  assign sck      = sck_q;
  assign conv_L   = conv_L_q;

endmodule

// File: tb/tb_adc_spi_reader.sv
// Directed bench for adc_spi_reader: three parameterisations, each driven by a behavioural SPI ADC target.
module tb_adc_spi_reader;

  localparam logic [2:0] POL_V = 3'b101;
  localparam logic [2:0] PH_V  = 3'b010;

  logic             clk = 1'b0;
  logic             rst_L;
  logic [2:0]       arm_v;
  logic [2:0]       miso_v;
  logic [2:0]       fin_v;
  logic [2:0]       sck_v;
  logic [2:0]       conv_v;
  logic [2:0][17:0] data_v;
  logic [2:0][17:0] word_v;
  logic [2:0]       prev_sck = 3'b101;
  int               idx [3] = '{18, 18, 18};

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  adc_spi_reader u0 (
    .clk(clk), .rst_L(rst_L), .arm(arm_v[0]), .finished(fin_v[0]), .data(data_v[0]),
    .miso(miso_v[0]), .sck(sck_v[0]), .conv_L(conv_v[0])
  );

  adc_spi_reader #(.POLARITY(0), .PHASE(1), .CYCLE_HALF_WAIT(3)) u1 (
    .clk(clk), .rst_L(rst_L), .arm(arm_v[1]), .finished(fin_v[1]), .data(data_v[1]),
    .miso(miso_v[1]), .sck(sck_v[1]), .conv_L(conv_v[1])
  );

  adc_spi_reader #(.CYCLE_HALF_WAIT(2)) u2 (
    .clk(clk), .rst_L(rst_L), .arm(arm_v[2]), .finished(fin_v[2]), .data(data_v[2]),
    .miso(miso_v[2]), .sck(sck_v[2]), .conv_L(conv_v[2])
  );

  // ADC target: PHASE 0 presents the MSB at conv_L fall and advances on trailing edges;
  // PHASE 1 presents each bit on the leading edge before the trailing sample edge.
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (conv_v[i]) begin
        idx[i] = PH_V[i] ? 18 : 17;
      end else if (sck_v[i] != prev_sck[i]) begin
        if ((!PH_V[i] && sck_v[i] == POL_V[i]) || (PH_V[i] && sck_v[i] != POL_V[i]))
          idx[i] = idx[i] - 1;
      end
      prev_sck[i] = sck_v[i];
      miso_v[i] = (idx[i] >= 0 && idx[i] < 18) ? word_v[i][idx[i]] : 1'b0;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Arms instance i, tracks conv_L/sck/finished timing relative to cycle 0 and checks the result.
  task automatic do_read(input int i, input logic [17:0] w, input logic [17:0] held,
                         input int exp_fin, input int drop_at, input string tag);
    int c = -1;
    int first_low = -1;
    int last_low = -1;
    int first_sck = -1;
    int fin_at = -1;
    int held_bad = 0;
    @(negedge clk);
    word_v[i] = w;
    arm_v[i] = 1'b1;
    for (int k = 0; k < 400; k++) begin
      @(posedge clk);
      #1;
      c++;
      if (fin_v[i]) begin
        fin_at = c;
        break;
      end
      if (!conv_v[i]) begin
        if (first_low < 0) first_low = c;
        last_low = c;
      end
      if (sck_v[i] != POL_V[i] && first_sck < 0) first_sck = c;
      if (data_v[i] != held) held_bad++;
      if (c == drop_at) arm_v[i] = 1'b0;
    end
    chk({tag, " fin_cycle"}, fin_at, exp_fin);
    chk({tag, " conv_first_low"}, first_low, 1);
    chk({tag, " conv_last_low"}, last_low, exp_fin - 1);
    chk({tag, " first_sck_edge"}, first_sck, 6);
    chk({tag, " data_held"}, held_bad, 0);
    chk({tag, " data"}, data_v[i], w);
    chk({tag, " conv_at_done"}, conv_v[i], 1'b1);
    chk({tag, " sck_at_done"}, sck_v[i], POL_V[i]);
  endtask

  task automatic release_arm(input int i, input string tag);
    @(negedge clk);
    arm_v[i] = 1'b0;
    @(posedge clk);
    #1;
    chk({tag, " fin_after_release"}, fin_v[i], 1'b0);
  endtask

  typedef struct {
    int          inst;
    logic [17:0] word;
    logic [17:0] held;
    int          fin_cyc;
  } vec_t;

  vec_t vt [5];

  initial begin
    vt[0] = '{0, 18'h2A5C3, 18'h00000, 78};
    vt[1] = '{1, 18'h20001, 18'h00000, 150};
    vt[2] = '{2, 18'h15555, 18'h00000, 114};
    vt[3] = '{0, 18'h00001, 18'h2A5C3, 78};
    vt[4] = '{0, 18'h3FFFF, 18'h00001, 78};

    rst_L  = 1'b0;
    arm_v  = '0;
    word_v = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst conv_L", conv_v, 3'b111);
    chk("rst finished", fin_v, 3'b000);
    chk("rst sck", sck_v, POL_V);
    chk("rst data0", data_v[0], 18'h0);
    @(negedge clk);
    rst_L = 1'b1;

    for (int v = 0; v < 5; v++) begin
      do_read(vt[v].inst, vt[v].word, vt[v].held, vt[v].fin_cyc, -1, $sformatf("vec%0d", v));
      release_arm(vt[v].inst, $sformatf("vec%0d", v));
    end

    // arm dropped mid-transfer: completes, finished pulses one cycle, FSM stays idle
    do_read(0, 18'h0F0F0, 18'h3FFFF, 78, 20, "drop20");
    @(posedge clk);
    #1;
    chk("drop20 fin_one_cycle", fin_v[0], 1'b0);
    for (int k = 0; k < 4; k++) begin
      @(posedge clk);
      #1;
      chk("drop20 idle", {conv_v[0], sck_v[0], fin_v[0]}, 3'b110);
    end

    // reset at cycle 30 aborts the transfer
    @(negedge clk);
    word_v[0] = 18'h2B00D;
    arm_v[0] = 1'b1;
    for (int c = 0; c < 30; c++) begin
      @(posedge clk);
      #1;
    end
    rst_L = 1'b0;
    arm_v[0] = 1'b0;
    @(posedge clk);
    #1;
    chk("midrst conv_L", conv_v[0], 1'b1);
    chk("midrst sck", sck_v[0], POL_V[0]);
    chk("midrst finished", fin_v[0], 1'b0);
    chk("midrst data", data_v[0], 18'h0);
    @(negedge clk);
    rst_L = 1'b1;
    do_read(0, 18'h2B00D, 18'h00000, 78, -1, "postrst");
    release_arm(0, "postrst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/adc_spi_reader.md
# adc_spi_reader

SPI initiator that reads one sample from an external SPI ADC: asserts `conv_L`, waits out conversion time, clocks `WID` bits in MSB-first on `miso`, then presents the word with an arm/finished handshake. It is the controller-side counterpart of the ADC simulation target used in control loop simulation, and is the block the control loop instantiates to fetch each measured value.

## Interface
Parameters:
- `WID`, 18: sample width in bits.
- `WID_LEN`, 5: width of the bit counter; must satisfy 2^`WID_LEN` > `WID`.
- `POLARITY`, 1: idle level of `sck`.
- `PHASE`, 0: 0 = sample on leading edge of each sck cycle; 1 = sample on trailing edge.
- `CYCLE_HALF_WAIT`, 1: sck half period is `CYCLE_HALF_WAIT`+1 clk cycles.
- `CONV_WAIT`, 4: `conv_L` is held low `CONV_WAIT`+1 cycles before the first sck edge.
- `TIMER_LEN`, 16: width of the shared wait timer; must hold max(`CONV_WAIT`, `CYCLE_HALF_WAIT`).

Ports:
- `clk` in 1: system clock.
- `rst_L` in 1: synchronous reset, active low.
- `arm` in 1: request one conversion; held high until `finished`.
- `finished` out 1: high while a completed sample is held and `arm` is still high.
- `data` out `WID`: last completed sample, raw two's-complement bits from the ADC.
- `miso` in 1: serial data from the ADC.
- `sck` out 1: serial clock.
- `conv_L` out 1: conversion start / select, active low.

## Operation
- States: IDLE, CONV, SHIFT, DONE.
- IDLE: `conv_L`=1, `sck`=`POLARITY`, `finished`=0. On `arm`=1 go to CONV; `conv_L` falls on the next edge.
- CONV: timer counts `CONV_WAIT`+1 cycles, then SHIFT.
- SHIFT: toggle `sck` every `CYCLE_HALF_WAIT`+1 cycles. Make 2·`WID` edges, which gives `WID` full sck cycles. Sample `miso` into the shift register on the edges selected by `PHASE`, MSB first. After the last edge, wait one more half period, then go to DONE. `sck` ends at `POLARITY`.
- DONE: load `data` from the shift register. Drive `conv_L`=1 and `finished`=1. Stay until `arm`=0, then drop `finished` on the next edge and return to IDLE.
- `arm` is ignored in CONV and SHIFT. Dropping `arm` mid-transfer does not abort the transfer. The transfer completes, `data` updates, and `finished` is high for exactly one cycle.
- `data` changes only on entry to DONE. It holds its value across later IDLE, CONV and SHIFT.

## Timing
- Reset (`rst_L`=0 at a rising edge) values: `conv_L`=1, `sck`=`POLARITY`, `finished`=0, `data`=0, state IDLE, counters 0. A reset mid-transfer aborts it with the same values on the next edge.
- Let cycle 0 be the edge where `arm`=1 is sampled in IDLE:
  - `conv_L`=0 from cycle 1.
  - First sck edge at cycle 2+`CONV_WAIT`.
  - Consecutive sck edges are `CYCLE_HALF_WAIT`+1 cycles apart.
  - `finished`=1, `conv_L`=1 and `data` valid at cycle 2+`CONV_WAIT`+2·`WID`·(`CYCLE_HALF_WAIT`+1).
- `finished` falls one cycle after `arm` is sampled low in DONE. A new `arm` is accepted no earlier than the cycle after that.
- Without the macro, `miso` is sampled in the same clk edge that produces the sampling sck edge. The ADC must therefore present each bit at least one half period before that edge.

## Configuration
- `ADC_SPI_READER_MISO_SYNC_EN`:
  - Defined: `miso` passes through a two-flop synchronizer, and the sampled value is the synchronizer output. The ADC bit must be stable for 2 clk cycles before the sampling edge. `CYCLE_HALF_WAIT` ≥ 2 is required; an elaboration `$error` fires otherwise.
  - Undefined: `miso` is sampled directly. Latency is identical in both cases.

## Test plan
- Defaults; target drives 18'h2A5C3 → `data`=18'h2A5C3, `finished` rises at cycle 78, `conv_L` low for cycles 1–77.
- `POLARITY`=0, `PHASE`=1, `CYCLE_HALF_WAIT`=3; target drives 18'h20001 → `data`=18'h20001, `sck` idles at 0, bits captured on falling edges.
- Back-to-back: samples 18'h00001 then 18'h3FFFF with `arm` dropped for 1 cycle between them → both read correctly; `data` holds 18'h00001 until the second DONE.
- `arm` dropped at cycle 20 → transfer completes, `finished` high for exactly 1 cycle, FSM returns to IDLE.
- `rst_L`=0 at cycle 30 → next cycle `conv_L`=1, `sck`=`POLARITY`, `finished`=0, `data`=0; a fresh `arm` then yields the correct sample.
- With `ADC_SPI_READER_MISO_SYNC_EN` and `CYCLE_HALF_WAIT`=2; target drives 18'h15555 → `data`=18'h15555.
